seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Display back-end for the temperature path: accepts a binary temperature word through a valid/ready handshake, converts it to BCD with a multi-cycle shift-add-3 (double-dabble) sequencer, and time-multiplexes the resulting digits onto a common-cathode-bus seven-segment display. The block sits directly downstream of the sensor wrapper's `data_out` and replaces ad-hoc per-value segment decoding and dual-edge digit switching with single-edge, counter-paced scanning.

## Interface
- `DATA_W`, 8: width of the binary input value.
- `DIGITS`, 3: number of display digits; digit 0 is the ones digit.
- `REFRESH_DIV`, 50000: clock cycles each digit stays lit; must be ≥ 2.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `data_in`  in  DATA_W  unsigned binary temperature.
- `data_valid`  in  1  `data_in` is valid this cycle.
- `data_ready`  out  1  high when the converter is idle and will accept.
- `cathode`  out  7  active-low segments, bit order {a,b,c,d,e,f,g} (bit 6 = a).
- `anode`  out  DIGITS  active-low digit enables; exactly one bit low after reset release.

## Operation
- Converter FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: `data_ready`=1. Transfer occurs on a rising edge with `data_valid`=1 and `data_ready`=1; `data_in` captured into the shift register, BCD accumulator cleared, iteration counter = 0, go to CONVERT.
  - CONVERT: each cycle, every BCD nibble ≥ 5 gets +3, then {bcd, bin} shifts left by 1; counter increments. After DATA_W iterations go to COMMIT.
  - COMMIT: if captured value ≥ 10^DIGITS, display register loads the overflow pattern (all digits dash); else loads the BCD result. Go to IDLE.
- `data_valid` while `data_ready`=0 is ignored; no queuing; upstream must hold or re-present.
- Scan: refresh counter counts 0..REFRESH_DIV-1 then wraps; on wrap the digit index increments modulo DIGITS (… DIGITS-1 → 0).
- `anode` = all ones except bit[index] low; `cathode` = encoding of display nibble [index]. Both registered, updated together on the same edge.
- Encodings (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, dash=1111110, blank=1111111.
- Display register changes only in COMMIT; a mid-scan update is picked up on the next cathode register load without resetting the scan index.

## Timing
- Reset values: `data_ready`=1, `cathode`=1111111, `anode`=all ones, display register=0, scan index=0, refresh counter=0, FSM=IDLE.
- First rising edge after reset deassertion: `anode`[0]=0, `cathode`=0000001.
- Handshake accepted at edge T: `data_ready`=0 from T; CONVERT during T+1..T+DATA_W; COMMIT edge T+DATA_W+1 updates display register; `cathode` reflects the new value from edge T+DATA_W+2 for the lit digit; `data_ready`=1 again after edge T+DATA_W+1 (back-to-back acceptance every DATA_W+2 cycles).
- Each digit lit exactly REFRESH_DIV cycles; full frame = DIGITS×REFRESH_DIV cycles.
- Reset asserted mid-conversion: conversion abandoned, all state returns to reset values immediately (asynchronous); no partial value reaches the display.

## Configuration
- `SEG7_LZ_BLANK_EN`: when defined, leading zero digits above the ones digit show blank (1111111); ones digit always shown; dash pattern unaffected. When undefined, all digits shown including leading zeros (value 7 on 3 digits → "007").

## Structure
- Shared package `seg7_pkg`: segment encoding constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK), converter state enum, nibble-to-segment function.
- One sub-module: `bin2bcd_seq` (the IDLE/CONVERT/COMMIT sequencer with valid/ready), instantiated by the scan logic in the top.

## Test plan
- Reset then idle, REFRESH_DIV=4, DIGITS=3: anode cycles 110→101→011→110, 4 cycles each; cathode 0000001 on every digit (LZ off).
- Send 25 at edge T: `data_ready` low T..T+9, digits ones=5 (0100100), tens=2 (0010010), hundreds=0; with `SEG7_LZ_BLANK_EN` hundreds=1111111.
- Send 255 with DIGITS=2: all digits 1111110 (overflow dash).
- Assert `data_valid` with 23 while converting 24: 23 ignored; display shows 24; re-present 23 after `data_ready` → shows 23.
- Assert `reset` 4 cycles into converting 199: outputs immediately 1111111/all-ones, display register 0; after release shows 000.
- Back-to-back 0, 23, 24, 25 with `data_valid` held: each accepted at `data_ready`, spaced 10 cycles; final display 025.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment encodings, converter states and nibble decode for seg7_scan_driver
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-BCD nibble code stored in the display register to mean "dash".
    localparam logic [3:0] NIB_DASH = 4'hA;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } conv_state_e;

    function automatic logic [6:0] nib_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:     seg = SEG_0;
            4'd1:     seg = SEG_1;
            4'd2:     seg = SEG_2;
            4'd3:     seg = SEG_3;
            4'd4:     seg = SEG_4;
            4'd5:     seg = SEG_5;
            4'd6:     seg = SEG_6;
            4'd7:     seg = SEG_7;
            4'd8:     seg = SEG_8;
            4'd9:     seg = SEG_9;
            NIB_DASH: seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - valid/ready port carrying the binary temperature word
interface seg7_scan_driver_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input  data_ready);
    modport slave  (input  data_in, input  data_valid, output data_ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - IDLE/CONVERT/COMMIT double-dabble sequencer with valid/ready intake
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                commit,
    output logic [4*DIGITS-1:0] result
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    conv_state_e          state_q, state_d;
    logic [DATA_W-1:0]    bin_q, bin_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    // A 1 leaving the top nibble means the value needs more than DIGITS digits.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_adj    = bcd_q;
        data_ready = 1'b0;
        commit     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    bin_d   = data_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                bcd_d = {bcd_adj[4*DIGITS-2:0], bin_q[DATA_W-1]};
                bin_d = bin_q << 1;
                ovf_d = ovf_q | bcd_adj[4*DIGITS-1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = ovf_q ? {DIGITS{NIB_DASH}} : bcd_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - BCD conversion plus counter-paced digit scan; SEG7_LZ_BLANK_EN blanks leading zeros
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clock,
    input  logic               reset,
    seg7_scan_driver_if.slave  in_if,
    output logic [6:0]         cathode,
    output logic [DIGITS-1:0]  anode
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);

    logic                 commit;
    logic [4*DIGITS-1:0]  result;
    logic [4*DIGITS-1:0]  disp_q, disp_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [REF_W-1:0]     ref_q, ref_d;
    logic [6:0]           cathode_q, cathode_d;
    logic [DIGITS-1:0]    anode_q, anode_d;
    logic [DIGITS-1:0]    blank_mask;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clock      (clock),
        .reset      (reset),
        .data_in    (in_if.data_in),
        .data_valid (in_if.data_valid),
        .data_ready (in_if.data_ready),
        .commit     (commit),
        .result     (result)
    );

`ifdef SEG7_LZ_BLANK_EN
    logic lz_seen;
    // A digit above the ones place blanks while it and everything above it are zero.
    always_comb begin
        lz_seen    = 1'b0;
        blank_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_seen       = lz_seen | (disp_q[4*i +: 4] != 4'd0);
            blank_mask[i] = ~lz_seen;
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        disp_d    = commit ? result : disp_q;
        ref_d     = ref_q + 1'b1;
        idx_d     = idx_q;
        anode_d   = '1;
        cathode_d = SEG_BLANK;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                anode_d[i] = 1'b0;
                cathode_d  = blank_mask[i] ? SEG_BLANK : nib_to_seg(disp_q[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp_q    <= '0;
            idx_q     <= '0;
            ref_q     <= '0;
            cathode_q <= SEG_BLANK;
            anode_q   <= '1;
        end else begin
            disp_q    <= disp_d;
            idx_q     <= idx_d;
            ref_q     <= ref_d;
            cathode_q <= cathode_d;
            anode_q   <= anode_d;
        end
    end

    assign cathode = cathode_q;
    assign anode   = anode_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (3-digit and 2-digit instances)
module tb_seg7_scan_driver;

    localparam int DATA_W = 8;
    localparam int RDIV   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] cath1, cath2;
    logic [2:0] an1;
    logic [1:0] an2;
    int         cyc;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         disp_model = 0;

    typedef struct {
        int val;
        int due;
    } exp_t;
    exp_t sb_q[$];

    seg7_scan_driver_if #(.DATA_W(DATA_W)) if1 ();
    seg7_scan_driver_if #(.DATA_W(DATA_W)) if2 ();

    seg7_scan_driver #(.DATA_W(DATA_W), .DIGITS(3), .REFRESH_DIV(RDIV)) dut1 (
        .clock   (clk),
        .reset   (rst),
        .in_if   (if1),
        .cathode (cath1),
        .anode   (an1)
    );

    seg7_scan_driver #(.DATA_W(DATA_W), .DIGITS(2), .REFRESH_DIV(RDIV)) dut2 (
        .clock   (clk),
        .reset   (rst),
        .in_if   (if2),
        .cathode (cath2),
        .anode   (an2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            default: return 7'b0000100;
        endcase
    endfunction

    function automatic int exp_seg(input int v, input int d, input int ndig);
        int lim;
        int pw;
        lim = 1;
        pw  = 1;
        for (int i = 0; i < ndig; i++) lim = lim * 10;
        for (int i = 0; i < d; i++) pw = pw * 10;
        if (v >= lim) return 7'b1111110;
`ifdef SEG7_LZ_BLANK_EN
        if (d > 0 && v < pw) return 7'b1111111;
`endif
        return seg_of((v / pw) % 10);
    endfunction

    function automatic int lit(input int ndig);
        return ((cyc - 1) / RDIV) % ndig;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            if (cyc == sb_q[0].due - 1) begin
                check_eq("pre_commit_seg", cath1, exp_seg(disp_model, lit(3), 3));
            end else if (cyc == sb_q[0].due) begin
                e = sb_q.pop_front();
                disp_model = e.val;
                check_eq("commit_seg", cath1, exp_seg(disp_model, lit(3), 3));
            end
        end
    endtask

    task automatic send(input int v, input bit hold, output int t_acc);
        int   w;
        exp_t e;
        if1.data_in    = v[DATA_W-1:0];
        if1.data_valid = 1'b1;
        w = 0;
        while (if1.data_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check_eq("accept_wait", (w < 40), 1);
        tick();
        t_acc = cyc;
        e.val = v;
        e.due = cyc + DATA_W + 2;
        sb_q.push_back(e);
        if (!hold) if1.data_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() > 0 && w < 40) begin
            tick();
            w++;
        end
        check_eq("drain", sb_q.size(), 0);
    endtask

    task automatic check_frame(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check_eq("anode", an1, 3'b111 & ~(3'b001 << lit(3)));
            check_eq("cathode", cath1, exp_seg(disp_model, lit(3), 3));
        end
    endtask

    task automatic check_dut2(input int v);
        int t;
        int w;
        if2.data_in    = v[DATA_W-1:0];
        if2.data_valid = 1'b1;
        w = 0;
        while (if2.data_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check_eq("d2_accept_wait", (w < 40), 1);
        tick();
        t = cyc;
        if2.data_valid = 1'b0;
        while (cyc < t + DATA_W + 2) tick();
        for (int k = 0; k < 2 * RDIV; k++) begin
            check_eq("d2_anode", an2, 2'b11 & ~(2'b01 << lit(2)));
            check_eq("d2_cathode", cath2, exp_seg(v, lit(2), 2));
            tick();
        end
    endtask

    initial begin
        int t;
        int tprev;
        if1.data_in    = '0;
        if1.data_valid = 1'b0;
        if2.data_in    = '0;
        if2.data_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", if1.data_ready, 1);
        check_eq("rst_cathode", cath1, 7'b1111111);
        check_eq("rst_anode", an1, 3'b111);
        check_eq("rst_anode2", an2, 2'b11);
        rst = 1'b0;
        check_frame(3 * RDIV + 1);

        send(25, 1'b0, t);
        for (int k = 0; k < DATA_W + 2; k++) begin
            check_eq("ready_busy", if1.data_ready, (k == DATA_W + 1));
            tick();
        end
        drain();
        check_frame(3 * RDIV);

        send(24, 1'b0, t);
        tick();
        tick();
        if1.data_in    = 8'd23;
        if1.data_valid = 1'b1;
        repeat (3) begin
            check_eq("busy_ready", if1.data_ready, 0);
            tick();
        end
        if1.data_valid = 1'b0;
        drain();
        check_frame(3 * RDIV);
        send(23, 1'b0, t);
        drain();
        check_frame(3 * RDIV);

        send(255, 1'b0, t);
        drain();
        check_frame(3 * RDIV);

        send(199, 1'b0, t);
        repeat (4) tick();
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_cathode", cath1, 7'b1111111);
        check_eq("midrst_anode", an1, 3'b111);
        check_eq("midrst_ready", if1.data_ready, 1);
        sb_q.delete();
        disp_model = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_frame(3 * RDIV + 1);

        send(0, 1'b1, tprev);
        send(23, 1'b1, t);
        check_eq("b2b_spacing", t - tprev, DATA_W + 2);
        tprev = t;
        send(24, 1'b1, t);
        check_eq("b2b_spacing", t - tprev, DATA_W + 2);
        tprev = t;
        send(25, 1'b1, t);
        check_eq("b2b_spacing", t - tprev, DATA_W + 2);
        if1.data_valid = 1'b0;
        drain();
        check_frame(3 * RDIV);

        check_dut2(255);
        check_dut2(99);
        check_dut2(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
